// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the main-memory arbiter: owner FSM states,
// owner identity and the 4-bit carry-lookahead increment used by the burst counters.
package mem_arbiter_pkg;

  localparam int BURST_WORDS_DEF = 8;
  localparam int ADDR_W_DEF      = 16;
  localparam int DATA_W_DEF      = 16;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IFILL  = 2'd1,
    ARB_DFILL  = 2'd2,
    ARB_DWRITE = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // +1 with every carry computed directly from the operand bits (CLA4 style).
  function automatic logic [CNT_W-1:0] cla4_inc(input logic [CNT_W-1:0] a);
    logic [CNT_W-1:0] c;
    c[0] = 1'b1;
    c[1] = a[0];
    c[2] = a[1] & a[0];
    c[3] = a[2] & a[1] & a[0];
    return a ^ c;
  endfunction

endpackage

// File: rtl/mem_arbiter_burst_counter.sv
// Saturating 4-bit burst word counter with synchronous clear, count enable
// and a done flag raised once the count reaches MAX_VAL.
module mem_arbiter_burst_counter
  import mem_arbiter_pkg::*;
#(
  parameter logic [CNT_W-1:0] MAX_VAL = CNT_W'(BURST_WORDS_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign done_o = (cnt_q == MAX_VAL);
  assign cnt_o  = cnt_q;

  // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !done_o) begin
      cnt_d = cla4_inc(cnt_q);
    end
  end

  // NOTE: registers use non-blocking assignments; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: grants the I-cache fill, D-cache fill or D-cache store
// one at a time, forwards the owner's address and routes read-valid back to the owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BURST_WORDS = BURST_WORDS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_valid,
  output logic              ic_grant,
  input  logic              dc_req,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_wr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_valid,
  output logic              dc_grant,
  output logic              dc_wr_done,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_data_valid
);

  arb_state_e       state_q, state_d;
  owner_e           last_owner_q, last_owner_d;
  logic [CNT_W-1:0] issue_cnt, ret_cnt;
  logic             issue_done, ret_done;
  logic             in_fill, issuing, burst_last, d_side;
  logic             unused_cnt_bits;

  assign in_fill    = (state_q == ARB_IFILL) || (state_q == ARB_DFILL);
  assign issuing    = in_fill && !issue_done;
  assign burst_last = in_fill && mem_data_valid && (ret_cnt == CNT_W'(BURST_WORDS - 1));
  assign d_side     = dc_wr || dc_req;

  mem_arbiter_burst_counter #(.MAX_VAL(CNT_W'(BURST_WORDS))) u_issue_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_d == ARB_IDLE),
    .en_i   (issuing),
    .cnt_o  (issue_cnt),
    .done_o (issue_done)
  );

  mem_arbiter_burst_counter #(.MAX_VAL(CNT_W'(BURST_WORDS))) u_ret_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_d == ARB_IDLE),
    .en_i   (in_fill && mem_data_valid),
    .cnt_o  (ret_cnt),
    .done_o (ret_done)
  );

  // Raw issue count and return-done flag are kept for debug visibility only.
  assign unused_cnt_bits = ^{issue_cnt, ret_done};

  // In a conflict the side that did not own memory last wins; a store beats a D fill.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (ic_req && (!d_side || last_owner_q == OWN_D)) begin
          state_d = ARB_IFILL;
        end else if (dc_wr) begin
          state_d = ARB_DWRITE;
        end else if (dc_req) begin
          state_d = ARB_DFILL;
        end
      end
      ARB_IFILL: begin
        if (burst_last) begin
          state_d      = ARB_IDLE;
          last_owner_d = OWN_I;
        end
      end
      ARB_DFILL: begin
        if (burst_last) begin
          state_d      = ARB_IDLE;
          last_owner_d = OWN_D;
        end
      end
      ARB_DWRITE: begin
        state_d      = ARB_IDLE;
        last_owner_d = OWN_D;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= OWN_D;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign ic_grant   = (state_q == ARB_IFILL);
  assign dc_grant   = (state_q == ARB_DFILL) || (state_q == ARB_DWRITE);
  assign dc_wr_done = (state_q == ARB_DWRITE);
  assign mem_enable = issuing || (state_q == ARB_DWRITE);
  assign mem_wr     = (state_q == ARB_DWRITE);
  assign mem_wdata  = (state_q == ARB_DWRITE) ? dc_wdata : '0;
  assign mem_addr   = (state_q == ARB_IFILL && issuing) ? ic_addr :
                      (((state_q == ARB_DFILL) && issuing) || (state_q == ARB_DWRITE)) ? dc_addr :
                      '0;

  // Returns outside a fill (idle, store, or after a reset) are dropped here.
  assign ic_valid = (state_q == ARB_IFILL) && mem_data_valid;
  assign dc_valid = (state_q == ARB_DFILL) && mem_data_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a fixed-latency memory model feeds returns,
// and each step compares the arbiter outputs with hand-derived values.
module tb_mem_arbiter;

  localparam int MEM_LATENCY = 4;
  localparam int BW          = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req, dc_req, dc_wr, mem_data_valid;
  logic [15:0] ic_addr, dc_addr, dc_wdata;
  logic        ic_valid, ic_grant, dc_valid, dc_grant, dc_wr_done, mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_arbiter #(.BURST_WORDS(BW), .ADDR_W(16), .DATA_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .ic_req         (ic_req),
    .ic_addr        (ic_addr),
    .ic_valid       (ic_valid),
    .ic_grant       (ic_grant),
    .dc_req         (dc_req),
    .dc_addr        (dc_addr),
    .dc_wr          (dc_wr),
    .dc_wdata       (dc_wdata),
    .dc_valid       (dc_valid),
    .dc_grant       (dc_grant),
    .dc_wr_done     (dc_wr_done),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_data_valid (mem_data_valid)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [MEM_LATENCY-1:0] rd_hist = '0;
  int cnt_en, cnt_icv, cnt_dcv, cnt_wr, cnt_done;
  bit overlap;
  logic prev_ic = 1'b0, prev_dc = 1'b0;
  int order_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Control outputs packed as {ic_grant, dc_grant, mem_enable, mem_wr, dc_wr_done, ic_valid, dc_valid}.
  function automatic logic [31:0] ctl();
    return 32'({ic_grant, dc_grant, mem_enable, mem_wr, dc_wr_done, ic_valid, dc_valid});
  endfunction

  function automatic logic [31:0] ctl_exp(input bit ig, dg, en, wr, dn, iv, dv);
    return 32'({ig, dg, en, wr, dn, iv, dv});
  endfunction

  task automatic clear_counts();
    cnt_en = 0; cnt_icv = 0; cnt_dcv = 0; cnt_wr = 0; cnt_done = 0; overlap = 1'b0;
  endtask

  // Close the current cycle (monitor + memory model), then advance to the next one.
  task automatic step();
    cnt_en   += int'(mem_enable && !mem_wr);
    cnt_icv  += int'(ic_valid);
    cnt_dcv  += int'(dc_valid);
    cnt_wr   += int'(mem_wr);
    cnt_done += int'(dc_wr_done);
    overlap  |= ic_grant && dc_grant;
    if (ic_grant && !prev_ic) order_q.push_back(1);
    if (dc_grant && !prev_dc) order_q.push_back(2);
    prev_ic = ic_grant;
    prev_dc = dc_grant;
    rd_hist = {rd_hist[MEM_LATENCY-2:0], mem_enable && !mem_wr};
    @(posedge clk);
    #1;
    mem_data_valid = rd_hist[MEM_LATENCY-1];
    #1;
  endtask

  // Run until the owner has received a full line; returns in the IDLE decision cycle.
  task automatic drain(input bit want_i);
    int base;
    base = want_i ? cnt_icv : cnt_dcv;
    for (int i = 0; i < 40; i++) begin
      step();
      if ((want_i ? cnt_icv : cnt_dcv) - base >= BW) break;
    end
    check(want_i ? "drain_i_words" : "drain_d_words", (want_i ? cnt_icv : cnt_dcv) - base, BW);
  endtask

  task automatic do_reset();
    rst = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_wr = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_wr = 1'b0; mem_data_valid = 1'b0;
    ic_addr = 16'h1230; dc_addr = 16'h0bad; dc_wdata = 16'hffff;
    clear_counts();
    step();
    step();
    check("reset_ctl",   ctl(), 32'h0);
    check("reset_addr",  32'(mem_addr), 32'h0);
    check("reset_wdata", 32'(mem_wdata), 32'h0);
    rst = 1'b0;
    step();

    // 1: isolated I-miss, request in cycle t
    clear_counts();
    ic_req = 1'b1; ic_addr = 16'h1230; #1;
    check("t1_req_cycle", ctl(), 32'h0);
    for (int k = 1; k <= 12; k++) begin
      step();
      ic_addr = 16'h1230 + 16'(2 * (k - 1));
      #1;
      check($sformatf("t1_ctl_c%0d", k), ctl(), ctl_exp(1, 0, k <= 8, 0, 0, k >= 5, 0));
      if (k <= 8) check($sformatf("t1_addr_c%0d", k), 32'(mem_addr), 32'(16'h1230 + 16'(2 * (k - 1))));
    end
    step();
    ic_req = 1'b0; #1;
    check("t1_idle_c13", ctl(), 32'h0);
    check("t1_issues",   cnt_en, 8);
    check("t1_ic_words", cnt_icv, 8);
    check("t1_dc_words", cnt_dcv, 0);

    // 2: simultaneous requests after reset -> I first, then D
    do_reset();
    clear_counts(); order_q.delete();
    ic_req = 1'b1; dc_req = 1'b1; ic_addr = 16'h2000; dc_addr = 16'h4000;
    step();
    check("t2_first_grant", ctl() & 32'h60, 32'h40);
    drain(1'b1);
    ic_req = 1'b0; #1;
    check("t2_decision_gap", ctl(), 32'h0);
    step();
    check("t2_d_grant", ctl() & 32'h70, 32'h30);
    check("t2_d_addr",  32'(mem_addr), 32'h4000);
    drain(1'b0);
    dc_req = 1'b0;
    step();
    check("t2_no_overlap",  32'(overlap), 32'h0);
    check("t2_order_len",   32'(order_q.size()), 32'd2);
    check("t2_order_first", order_q[0], 1);
    check("t2_order_second", order_q[1], 2);

    // 3: store arriving mid I-fill waits, then one-cycle write
    clear_counts();
    ic_req = 1'b1; ic_addr = 16'h3000;
    step();
    step();
    step();
    step();
    dc_wr = 1'b1; dc_addr = 16'h5550; dc_wdata = 16'hbeef; #1;
    check("t3_store_waits", ctl(), ctl_exp(1, 0, 1, 0, 0, 0, 0));
    drain(1'b1);
    ic_req = 1'b0; #1;
    check("t3_decision_gap", ctl(), 32'h0);
    check("t3_no_early_wr",  cnt_wr, 0);
    step();
    check("t3_dwrite_ctl", ctl(), ctl_exp(0, 1, 1, 1, 1, 0, 0));
    check("t3_dwrite_addr",  32'(mem_addr), 32'h5550);
    check("t3_dwrite_wdata", 32'(mem_wdata), 32'hbeef);
    dc_wr = 1'b0;
    step();
    check("t3_after_write", ctl(), 32'h0);
    check("t3_wdata_idle",  32'(mem_wdata), 32'h0);
    check("t3_one_write",   cnt_wr, 1);
    check("t3_one_done",    cnt_done, 1);

    // 4: owner drops ic_req after 3 issues; burst still completes
    clear_counts();
    ic_req = 1'b1; ic_addr = 16'h3400;
    step();
    step();
    step();
    step();
    ic_req = 1'b0; #1;
    check("t4_grant_kept", ctl(), ctl_exp(1, 0, 1, 0, 0, 0, 0));
    drain(1'b1);
    check("t4_issues", cnt_en, 8);
    step();
    mem_data_valid = 1'b1; #1;
    check("t4_spurious_valid", ctl(), 32'h0);
    step();

    // 5: reset at the 5th return of a D-fill drops the rest
    clear_counts();
    dc_req = 1'b1; dc_addr = 16'h6000;
    for (int k = 1; k <= 9; k++) step();
    check("t5_fifth_return", ctl(), ctl_exp(0, 1, 0, 0, 0, 0, 1));
    check("t5_words_before", cnt_dcv, 4);
    rst = 1'b1; dc_req = 1'b0;
    step();
    rst = 1'b0;
    check("t5_reset_addr", 32'(mem_addr), 32'h0);
    for (int k = 10; k <= 12; k++) begin
      check($sformatf("t5_dropped_c%0d", k), ctl(), 32'h0);
      step();
    end
    check("t5_words_total", cnt_dcv, 5);
    clear_counts();
    dc_req = 1'b1; dc_addr = 16'h7000;
    step();
    check("t5_new_grant", ctl(), ctl_exp(0, 1, 1, 0, 0, 0, 0));
    check("t5_new_addr",  32'(mem_addr), 32'h7000);
    drain(1'b0);
    dc_req = 1'b0;
    step();
    check("t5_new_issues", cnt_en, 8);

    // 6: back-to-back D fills with ic_req held -> D, I, D
    clear_counts(); order_q.delete();
    dc_req = 1'b1; dc_addr = 16'h8000;
    step();
    ic_req = 1'b1; ic_addr = 16'h9000; #1;
    check("t6_i_waits", ctl() & 32'h60, 32'h20);
    drain(1'b0);
    step();
    check("t6_i_turn", ctl() & 32'h60, 32'h40);
    drain(1'b1);
    step();
    check("t6_d_turn", ctl() & 32'h60, 32'h20);
    drain(1'b0);
    ic_req = 1'b0; dc_req = 1'b0;
    step();
    step();
    check("t6_no_overlap", 32'(overlap), 32'h0);
    check("t6_order_len",  32'(order_q.size()), 32'd3);
    check("t6_order_0",    order_q[0], 2);
    check("t6_order_1",    order_q[1], 1);
    check("t6_order_2",    order_q[2], 2);
    check("t6_d_words",    cnt_dcv, 16);
    check("t6_i_words",    cnt_icv, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
